// File: rtl/aes_pkg.sv
// Shared AES helpers: S-box, round constants and the GF(2^8) doubling used by MixColumns.
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int AES_NK = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ark_state_t;

    // Entry 0 sits in the most significant byte of the concatenation.
    localparam logic [0:255][7:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[b];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] v;
        case (idx)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_subword.sv
// Four parallel S-box lookups over a 32-bit word; shared with the SubBytes stage.
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                     sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

// File: rtl/add_round_key_sched.sv
// AES-128 AddRoundKey with an on-the-fly key schedule and a single-entry output register.
module add_round_key_sched
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         keyLoad,
    input  logic [127:0] keyIn,
    input  logic         inValid,
    output logic         inReady,
    input  logic [127:0] stateIn,
    output logic         outValid,
    input  logic         outReady,
    output logic [127:0] stateOut,
    output logic [3:0]   roundOut,
    output logic         lastRound,
    output logic         busy
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    ark_state_t   r_state;
    logic [127:0] r_key;
    logic [3:0]   r_rnd;
    logic         r_out_valid;
    logic [127:0] r_state_out;
    logic [3:0]   r_round_out;

    logic         w_accept;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [127:0] w_next_key;

    assign w_rot = {r_key[23:0], r_key[31:24]};

    aes_subword u_subword (
        .i_word (w_rot),
        .o_word (w_sub)
    );

    // Next round key: w0' depends on the rotated/substituted w3, then a ripple of XORs.
    assign w_t        = w_sub ^ {rcon(r_rnd + 4'd1), 24'h0};
    assign w_w0       = r_key[127:96] ^ w_t;
    assign w_w1       = r_key[95:64]  ^ w_w0;
    assign w_w2       = r_key[63:32]  ^ w_w1;
    assign w_w3       = r_key[31:0]   ^ w_w2;
    assign w_next_key = {w_w0, w_w1, w_w2, w_w3};

    // Handshake: a transfer happens on any cycle where valid and ready are both high.
    assign inReady  = (r_state == ST_RUN) && !keyLoad && (!r_out_valid || outReady);
    assign w_accept = inValid && inReady;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_key   <= '0;
            r_rnd   <= '0;
        end else if (keyLoad) begin
            r_state <= ST_RUN;
            r_key   <= keyIn;
            r_rnd   <= '0;
        end else if (w_accept) begin
            if (r_rnd == LAST_RND) begin
                r_state <= ST_IDLE;
            end else begin
                r_key <= w_next_key;
                r_rnd <= r_rnd + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_state_out <= '0;
            r_round_out <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_state_out <= stateIn ^ r_key;
            r_round_out <= r_rnd;
        end else if (outReady) begin
            r_out_valid <= 1'b0;
        end
    end

    assign outValid  = r_out_valid;
    assign stateOut  = r_state_out;
    assign roundOut  = r_round_out;
    assign lastRound = r_out_valid && (r_round_out == LAST_RND);
    assign busy      = (r_state == ST_RUN);

endmodule

// File: tb/tb_add_round_key_sched.sv
// Directed bench for add_round_key_sched using FIPS-197 round-key vectors.
module tb_add_round_key_sched;

    logic         clk;
    logic         reset;
    logic         keyLoad;
    logic [127:0] keyIn;
    logic         inValid;
    logic         inReady;
    logic [127:0] stateIn;
    logic         outValid;
    logic         outReady;
    logic [127:0] stateOut;
    logic [3:0]   roundOut;
    logic         lastRound;
    logic         busy;

    int checks;
    int errors;

    localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK_A0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK_A1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK_A2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] RK_A10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_B   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] OUT_B0 = 128'h00102030405060708090a0b0c0d0e0f0;

    add_round_key_sched dut (
        .clk       (clk),
        .reset     (reset),
        .keyLoad   (keyLoad),
        .keyIn     (keyIn),
        .inValid   (inValid),
        .inReady   (inReady),
        .stateIn   (stateIn),
        .outValid  (outValid),
        .outReady  (outReady),
        .stateOut  (stateOut),
        .roundOut  (roundOut),
        .lastRound (lastRound),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        keyLoad  = 1'b0;
        keyIn    = '0;
        inValid  = 1'b1;
        stateIn  = '0;
        outReady = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        check("reset_inready",  128'(inReady),   128'(0));
        check("reset_outvalid", 128'(outValid),  128'(0));
        check("reset_stateout", stateOut,        '0);
        check("reset_busy",     128'(busy),      128'(0));
        check("reset_last",     128'(lastRound), 128'(0));
        inValid = 1'b0;

        // Round 0 and round 1 of FIPS-197 Appendix B
        keyLoad = 1'b1;
        keyIn   = KEY_A;
        step();
        keyLoad = 1'b0;
        inValid = 1'b1;
        stateIn = 128'h3243f6a8885a308d313198a2e0370734;
        #1;
        check("load_busy",    128'(busy),    128'(1));
        check("load_inready", 128'(inReady), 128'(1));
        step();
        check("r0_valid", 128'(outValid), 128'(1));
        check("r0_state", stateOut, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        check("r0_round", 128'(roundOut), 128'(0));
        stateIn = 128'h046681e5e0cb199a48f8d37a2806264c;
        step();
        check("r1_state", stateOut, 128'ha49c7ff2689f352b6b5bea43026a5049);
        check("r1_round", 128'(roundOut), 128'(1));
        inValid = 1'b0;
        step();
        check("drain_valid", 128'(outValid), 128'(0));

        // Full 11-round sequence with zero state: outputs equal the round keys
        keyLoad = 1'b1;
        keyIn   = KEY_A;
        step();
        keyLoad = 1'b0;
        inValid = 1'b1;
        stateIn = '0;
        for (int i = 0; i <= 10; i++) begin
            step();
            check("full_valid", 128'(outValid), 128'(1));
            check("full_round", 128'(roundOut), 128'(i));
            check("full_last", 128'(lastRound), 128'(i == 10));
            if (i == 0) check("full_rk0", stateOut, RK_A0);
            if (i == 1) check("full_rk1", stateOut, RK_A1);
            if (i == 2) check("full_rk2", stateOut, RK_A2);
            if (i == 10) check("full_rk10", stateOut, RK_A10);
        end
        check("end_inready", 128'(inReady), 128'(0));
        check("end_busy",    128'(busy),    128'(0));
        step();
        check("end_no_accept", 128'(outValid), 128'(0));
        inValid = 1'b0;

        // Backpressure: hold the consumer off for three cycles after round 0
        keyLoad = 1'b1;
        keyIn   = KEY_A;
        step();
        keyLoad = 1'b0;
        inValid = 1'b1;
        stateIn = '0;
        step();
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_inready", 128'(inReady),  128'(0));
            check("bp_valid",   128'(outValid), 128'(1));
            check("bp_state",   stateOut,       RK_A0);
            check("bp_round",   128'(roundOut), 128'(0));
            step();
        end
        outReady = 1'b1;
        #1;
        check("bp_release_inready", 128'(inReady), 128'(1));
        step();
        check("bp_next_state", stateOut, RK_A1);
        check("bp_next_round", 128'(roundOut), 128'(1));
        inValid = 1'b0;
        step();

        // Abort in round 5 with a simultaneous inValid
        keyLoad = 1'b1;
        keyIn   = KEY_A;
        step();
        keyLoad = 1'b0;
        inValid = 1'b1;
        stateIn = '0;
        for (int i = 0; i < 5; i++) step();
        check("abort_pre_round", 128'(roundOut), 128'(4));
        keyLoad = 1'b1;
        keyIn   = KEY_B;
        stateIn = PT_B;
        #1;
        check("abort_inready", 128'(inReady), 128'(0));
        step();
        keyLoad = 1'b0;
        check("abort_no_accept", 128'(outValid), 128'(0));
        #1;
        check("abort_new_inready", 128'(inReady), 128'(1));
        step();
        check("abort_state", stateOut, OUT_B0);
        check("abort_round", 128'(roundOut), 128'(0));

        // Asynchronous reset mid-cycle while an output is pending
        stateIn = '0;
        step();
        #2;
        reset = 1'b1;
        #1;
        check("async_valid",   128'(outValid),  128'(0));
        check("async_state",   stateOut,        '0);
        check("async_round",   128'(roundOut),  128'(0));
        check("async_busy",    128'(busy),      128'(0));
        check("async_inready", 128'(inReady),   128'(0));
        check("async_last",    128'(lastRound), 128'(0));
        inValid = 1'b0;
        step();
        reset = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_round_key_sched.md
# add_round_key_sched

Applies AES-128 AddRoundKey to each round state and generates the round keys on the fly from the cipher key. It sits directly downstream of the MixColumns stage and accepts that stage's 128-bit output through a valid/ready handshake. For every accepted state it emits `state ^ roundKey[r]`, then advances the key schedule by one round. It removes the need for a precomputed 1408-bit expanded-key store.

## Interface
- `NR`, default 10: number of rounds after the initial AddRoundKey. AES-128 only; the key length Nk = 4 is fixed.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `keyLoad`, in, 1: pulse that latches `keyIn` as round key 0 and restarts the schedule.
- `keyIn`, in, 128: cipher key. Bits [127:96] = w0, [31:0] = w3.
- `inValid`, in, 1: `stateIn` is valid.
- `inReady`, out, 1: the block accepts `stateIn` this cycle.
- `stateIn`, in, 128: state from MixColumns, or the plaintext for round 0. Column c occupies [127-32c -: 32].
- `outValid`, out, 1: `stateOut` is valid.
- `outReady`, in, 1: the consumer accepts `stateOut`.
- `stateOut`, out, 128: `stateIn ^ roundKey[round]`, registered.
- `roundOut`, out, 4: round index (0..NR) of the key applied to `stateOut`.
- `lastRound`, out, 1: `roundOut == NR`; qualified by `outValid`.
- `busy`, out, 1: the schedule is loaded and not yet exhausted.

## Operation
- FSM states:
  - IDLE: no key loaded.
  - RUN: key loaded, rounds remaining.
- Transitions:
  - `keyLoad` in any state: `keyReg` ← `keyIn`, `rnd` ← 0, go to RUN.
  - In RUN, an accept (`inValid && inReady`) registers `stateOut` = `stateIn ^ keyReg` and `roundOut` = `rnd`, sets `outValid`, replaces `keyReg` with the next round key, and sets `rnd` ← `rnd + 1`.
  - An accept with `rnd == NR` returns to IDLE. `keyReg` is not advanced past round NR.
- Next-key expansion, combinational from `keyReg`:
  - t = SubWord(RotWord(w3)) ^ {Rcon[rnd+1], 24'h0}.
  - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
  - RotWord({a,b,c,d}) = {b,c,d,a}.
- Ready rule: `inReady = (state == RUN) && !keyLoad && (!outValid || outReady)`.
- Output register is single-entry:
  - `outValid` clears on `outReady` unless a new accept occurs in the same cycle.
  - `stateOut` and `roundOut` hold while `outValid && !outReady`.
- `keyLoad` in RUN aborts the current key. `keyLoad` has priority over `inValid` in the same cycle, and `inReady` is 0 in that cycle. A pending output is kept until it is consumed.
- `inValid` in IDLE is ignored; `inReady` = 0.
- `busy = (state == RUN)`.

## Timing
- Reset values: `state` = IDLE, `keyReg` = 0, `rnd` = 0, `outValid` = 0, `stateOut` = 0, `roundOut` = 0, `inReady` = 0, `busy` = 0, `lastRound` = 0.
- `keyLoad` at edge N: `busy` = 1 and `inReady` = 1 from cycle N+1, provided the output is free.
- Latency is 1 cycle from accept to `outValid`.
- Throughput is one state per cycle while `outReady` = 1. A full NR+1 sequence takes 11 accept cycles.
- The critical path is the 4 S-box lookups plus the XOR chain into `keyReg`. The `stateIn` XOR path is a single level.
- A reset assertion mid-sequence returns the block to reset values immediately. The consumer must then discard any partially processed block.

## Structure
- Shared package `aes_pkg` holds:
  - the `sbox` byte function (256-entry table),
  - the `Rcon` table function (index 1..10),
  - constants `AES_NR = 10` and `AES_NK = 4`,
  - the `xtime` function shared with MixColumns.
- One sub-module, `aes_subword`: 32-bit in, 32-bit out, four parallel `sbox` lookups. It is also reused by the encryption SubBytes stage.
- The FSM, round counter, key register and output register stay in `add_round_key_sched`.

## Test plan
- Reset check: assert `reset` asynchronously mid-cycle → all outputs 0 immediately, `inReady` = 0.
- Round 0 (FIPS-197 App. B):
  - Stimulus: `keyLoad` with `keyIn` = 2b7e151628aed2a6abf7158809cf4f3c, then `stateIn` = 3243f6a8885a308d313198a2e0370734.
  - Response: `stateOut` = 193de3bea0f4e22b9ac68d2ae9f84808, `roundOut` = 0, one cycle later.
- Round 1: next `stateIn` = 046681e5e0cb199a48f8d37a2806264c → `stateOut` = a49c7ff2689f352b6b5bea43026a5049, `roundOut` = 1 (round key a0fafe1788542cb123a339392a6c7605).
- Full sequence:
  - Stimulus: 11 back-to-back accepts of `stateIn` = 0 with `outReady` = 1.
  - Response: `stateOut` on the 11th output = d014f9a8c9ee2589e13f0cc8b6630ca6, `lastRound` = 1.
  - The 12th `inValid` is not accepted (`inReady` = 0, `busy` = 0).
- Backpressure:
  - Stimulus: hold `outReady` = 0 for 3 cycles after an accept.
  - Response: `inReady` = 0, `stateOut` and `roundOut` stable; on release the next accept proceeds with the correct key.
- Abort: `keyLoad` together with `inValid` in round 5 → no accept that cycle, next accepted output has `roundOut` = 0 with the new key.
